mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store access unit of the multicycle CPU; sits directly upstream of the memory data register.
- Takes one access request from the control unit (address from the ALU output register, store data from register B) and drives the word-wide memory port, tolerating wait states.
- For loads, performs byte/halfword lane extraction and sign/zero extension, then presents the final 32-bit value that the memory data register latches.

Parameters:
- MAX_WAIT, 15, maximum cycles spent in ACCESS waiting for mem_ready before aborting with timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  1  start access; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- sign_ext  in  1  loads only; 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err_align  out  1  valid with done: misaligned or illegal size.
- err_timeout  out  1  valid with done: mem_ready not seen within MAX_WAIT cycles.
- rdata  out  32  extended load result; feeds the memory data register input.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_en  out  1  memory request.
- mem_be  out  4  byte write enables, lane i = bits [8i+7:8i], little-endian.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  memory read word.
- mem_ready  in  1  memory completes the access this cycle.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, err_align, err_timeout, mem_en = 0; mem_be = 0; rdata, mem_addr, mem_wdata = 0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On req=1, latch we, size, sign_ext, addr, wdata.
  - Misaligned or illegal request (size=11; size=01 with addr[0]=1; size=10 with addr[1:0]!=0): go to DONE with err_align=1. No memory cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS:
  - mem_en=1 with mem_addr and mem_be held constant.
  - mem_be for stores: byte = one-hot at addr[1:0]; halfword = 0011 or 1100 per addr[1]; word = 1111. mem_be = 0 for loads.
  - mem_wdata: byte = {4{wdata[7:0]}}; halfword = {2{wdata[15:0]}}; word = wdata.
  - mem_ready=1: go to DONE. For a load, rdata is loaded with the extracted, extended value in the same edge.
  - Wait counter increments each ACCESS cycle. If it reaches MAX_WAIT with mem_ready still 0: go to DONE with err_timeout=1; rdata unchanged.
- DONE:
  - done=1 for exactly one cycle; mem_en=0, mem_be=0; then return to IDLE.
  - Error flags are cleared on the next entry to ACCESS or DONE.
- Latency: req at edge N sets mem_en at N+1. If mem_ready is already high at that edge, done pulses in the cycle after N+2, giving minimum 3 cycles from req to done. Each wait cycle adds 1.
- rdata changes only on a successful load completion; it is held through stores, errors, and idle.
- Load extraction:
  - Byte: mem_rdata[8*addr[1:0]+:8].
  - Half: mem_rdata[16*addr[1]+:16].
  - Extension: sign_ext ? replicate MSB : zeros.
- req while busy is ignored, not queued. req is re-sampled in IDLE the cycle after DONE.
- Reset mid-access drops mem_en immediately; no done pulse is produced.
- mem_ready outside ACCESS is ignored.

Test Plan:
- Word load, addr=0x100, mem_rdata=0xDEADBEEF, mem_ready high on first mem_en cycle -> mem_addr=0x100, done 3 cycles after req, rdata=0xDEADBEEF, no errors.
- Byte load sign_ext=1, addr=0x103, mem_rdata=0x80112233 -> rdata=0xFFFFFF80. Same access with sign_ext=0 -> rdata=0x00000080.
- Halfword store, addr=0x202, wdata=0x0000ABCD -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCDABCD, done pulses once, rdata unchanged.
- Word load, addr=0x006 -> err_align=1 with done, mem_en never asserted. Then size=11 -> err_align=1.
- mem_ready held low -> mem_en high exactly 15 cycles, then done with err_timeout=1. Repeat with 4 wait states -> done 7 cycles after req, no error; a second req pulsed during busy is ignored.
- rst_n low during a wait state -> all outputs 0 asynchronously, no done; next req completes normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Control-side and memory-side signals of the load/store access unit.
// Handshake: req is sampled only when busy=0 and is never queued; done pulses
// for one cycle per accepted req; a memory beat completes on a cycle with mem_en=1 and mem_ready=1.
interface mem_access_unit_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err_align;
  logic        err_timeout;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_en;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_rdata, mem_ready,
    output busy, done, err_align, err_timeout, rdata, mem_addr, mem_en, mem_be, mem_wdata
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_rdata, mem_ready,
    input  busy, done, err_align, err_timeout, rdata, mem_addr, mem_en, mem_be, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Multicycle-CPU load/store unit: issues one word-wide memory access per request,
// tolerates wait states with a timeout, and extends load data for the MDR.
module mem_access_unit #(
  parameter int MAX_WAIT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_access_unit_if.slave   bus,
  output logic [1:0]         o_dbg_state
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [1:0]  r_size;
  logic        r_sign;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [CW-1:0] r_wait;
  logic [31:0] r_rdata;
  logic        r_err_align;
  logic        r_err_timeout;

  logic        w_misalign;
  logic [3:0]  w_be_req;
  logic [31:0] w_wdata_req;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;

  assign w_misalign = (bus.size == 2'b11) ||
                      (bus.size == 2'b01 && bus.addr[0]) ||
                      (bus.size == 2'b10 && bus.addr[1:0] != 2'b00);

  // Byte enables are only meaningful for stores; loads always read the whole word.
  always_comb begin
    w_be_req    = 4'b0000;
    w_wdata_req = bus.wdata;
    case (bus.size)
      2'b00: begin
        w_wdata_req = {4{bus.wdata[7:0]}};
        if (bus.we) w_be_req = 4'b0001 << bus.addr[1:0];
      end
      2'b01: begin
        w_wdata_req = {2{bus.wdata[15:0]}};
        if (bus.we) w_be_req = bus.addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        if (bus.we) w_be_req = 4'b1111;
      end
      default: begin
        w_be_req = 4'b0000;
      end
    endcase
  end

  assign w_byte = bus.mem_rdata[{r_addr[1:0], 3'b000} +: 8];
  assign w_half = bus.mem_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (r_size)
      2'b00:   w_load = {{24{r_sign & w_byte[7]}}, w_byte};
      2'b01:   w_load = {{16{r_sign & w_half[15]}}, w_half};
      default: w_load = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.req) w_next = w_misalign ? S_DONE : S_ACCESS;
      end
      S_ACCESS: begin
        if (bus.mem_ready || r_wait == LAST_WAIT) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy        = (r_state != S_IDLE);
    bus.done        = (r_state == S_DONE);
    bus.mem_en      = (r_state == S_ACCESS);
    bus.mem_be      = (r_state == S_ACCESS) ? r_be : 4'b0000;
    bus.mem_addr    = {r_addr[31:2], 2'b00};
    bus.mem_wdata   = r_wdata;
    bus.rdata       = r_rdata;
    bus.err_align   = r_err_align;
    bus.err_timeout = r_err_timeout;
    o_dbg_state     = r_state;
  end

  // Request fields are latched on acceptance; error flags persist until the next request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we          <= 1'b0;
      r_size        <= 2'b00;
      r_sign        <= 1'b0;
      r_addr        <= 32'h0;
      r_wdata       <= 32'h0;
      r_be          <= 4'b0000;
      r_wait        <= '0;
      r_rdata       <= 32'h0;
      r_err_align   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req) begin
            r_we          <= bus.we;
            r_size        <= bus.size;
            r_sign        <= bus.sign_ext;
            r_addr        <= bus.addr;
            r_wdata       <= w_wdata_req;
            r_be          <= w_be_req;
            r_wait        <= '0;
            r_err_align   <= w_misalign;
            r_err_timeout <= 1'b0;
          end
        end
        S_ACCESS: begin
          if (bus.mem_ready) begin
            if (!r_we) r_rdata <= w_load;
          end else if (r_wait == LAST_WAIT) begin
            r_err_timeout <= 1'b1;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against an arithmetic reference model.
module tb_mem_access_unit;

  localparam int MAX_WAIT = 15;

  logic        clk;
  logic        rst_n;
  logic [1:0]  dbg_state;
  int          checks;
  int          errors;
  logic [31:0] model_rdata;

  mem_access_unit_if bus();

  mem_access_unit #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] sz);
    return (sz == 2'b11) ? 4 : (1 << sz);
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sx,
                                             input logic [31:0] a, input logic [31:0] w);
    int nb;
    logic [31:0] v;
    logic [31:0] mask;
    nb = nbytes_of(sz);
    if (nb >= 4) return w;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (w >> (8 * (a % 4))) & mask;
    if (sx && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  // One complete request; waits = ready-low cycles before completion (>= MAX_WAIT means never ready).
  task automatic do_access(input logic we_i, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                           input int waits, input bit extra_req);
    logic        exp_align;
    logic        exp_to;
    int          nb;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    int          exp_lat;
    int          exp_en;
    int          en_cnt;
    int          lat;
    bit          seen;

    nb        = nbytes_of(sz);
    exp_align = (sz == 2'b11) || ((a % nb) != 0);
    exp_to    = !exp_align && (waits >= MAX_WAIT);
    exp_be    = we_i ? 4'(((1 << nb) - 1) << (a % 4)) : 4'b0000;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wd[8*(i % nb) +: 8];
    if (exp_align)   begin exp_en = 0;         exp_lat = 2; end
    else if (exp_to) begin exp_en = MAX_WAIT;  exp_lat = MAX_WAIT + 2; end
    else             begin exp_en = waits + 1; exp_lat = waits + 3; end

    @(negedge clk);
    bus.req = 1'b1; bus.we = we_i; bus.size = sz; bus.sign_ext = sx;
    bus.addr = a; bus.wdata = wd;
    en_cnt = 0; lat = 0; seen = 0;
    for (int n = 2; n <= 40 && !seen; n++) begin
      @(negedge clk);
      bus.req = extra_req && (n == 3);
      if (bus.mem_en) begin
        en_cnt++;
        check("mem_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
        check("mem_be", {28'h0, bus.mem_be}, {28'h0, exp_be});
        if (we_i) check("mem_wdata", bus.mem_wdata, exp_wd);
        bus.mem_ready = (en_cnt > waits);
        bus.mem_rdata = bus.mem_ready ? rd : $urandom();
      end
      if (bus.done) begin
        seen = 1;
        lat  = n;
        bus.mem_ready = 1'b0;
        check("err_align", {31'h0, bus.err_align}, {31'h0, exp_align});
        check("err_timeout", {31'h0, bus.err_timeout}, {31'h0, exp_to});
      end
    end
    bus.mem_ready = 1'b0;
    check("done_seen", {31'h0, seen}, 32'h1);
    check("latency", lat, exp_lat);
    check("mem_en_cycles", en_cnt, exp_en);
    if (!exp_align && !exp_to && !we_i) model_rdata = model_load(sz, sx, a, rd);
    check("rdata", bus.rdata, model_rdata);
    @(negedge clk);
    check("done_one_cycle", {31'h0, bus.done}, 32'h0);
    check("busy_after", {31'h0, bus.busy}, 32'h0);
    check("rdata_hold", bus.rdata, model_rdata);
  endtask

  initial begin
    logic [1:0]  r_sz;
    logic [31:0] r_a;
    int          r_w;

    checks = 0; errors = 0; model_rdata = 32'h0;
    rst_n = 1'b0;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
    bus.addr = 32'h0; bus.wdata = 32'h0; bus.mem_rdata = 32'h0; bus.mem_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, bus.busy}, 32'h0);
    check("rst_done", {31'h0, bus.done}, 32'h0);
    check("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    rst_n = 1'b1;

    do_access(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    do_access(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1'b0);
    check("lb_sign", bus.rdata, 32'hFFFF_FF80);
    do_access(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 1'b0);
    check("lb_zero", bus.rdata, 32'h0000_0080);
    do_access(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h1234_5678, 0, 1'b0);
    check("sh_rdata_kept", bus.rdata, 32'h0000_0080);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 32'h1111_1111, 0, 1'b0);
    do_access(1'b0, 2'b11, 1'b0, 32'h0000_0008, 32'h0, 32'h2222_2222, 0, 1'b0);
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h3333_3333, 99, 1'b0);
    do_access(1'b0, 2'b01, 1'b1, 32'h0000_0402, 32'h0, 32'h9abc_0000, 4, 1'b1);

    // Reset while the unit is stalled in a wait state.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'b10; bus.addr = 32'h0000_0300;
    bus.wdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_mem_en", {31'h0, bus.mem_en}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("arst_busy", {31'h0, bus.busy}, 32'h0);
    check("arst_done", {31'h0, bus.done}, 32'h0);
    check("arst_mem_be", {28'h0, bus.mem_be}, 32'h0);
    check("arst_rdata", bus.rdata, 32'h0);
    check("arst_mem_addr", bus.mem_addr, 32'h0);
    check("arst_mem_wdata", bus.mem_wdata, 32'h0);
    model_rdata = 32'h0;
    @(negedge clk);
    check("arst_no_done", {31'h0, bus.done}, 32'h0);
    rst_n = 1'b1;
    do_access(1'b0, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h0BAD_CAFE, 1, 1'b0);

    for (int k = 0; k < 24; k++) begin
      r_sz = 2'($urandom_range(0, 3));
      r_a  = $urandom();
      if ($urandom_range(0, 3) != 0) r_a = r_a & ~((32'd1 << r_sz) - 32'd1);
      r_w  = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(0, 5);
      do_access(1'($urandom_range(0, 1)), r_sz, 1'($urandom_range(0, 1)), r_a,
                $urandom(), $urandom(), r_w, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
